// File: rtl/tea_io_mailbox.sv
// Purpose: IO-bus mailbox between a 64-bit host block stream and tea_cpu firmware (8 byte regs + status).
// Latency: block visible to firmware the cycle after accept; result valid the cycle after the firmware done write.
// Backpressure: in_ready is high only in IDLE; the result is held on out_data until out_ready is seen.
//
// Ports:
//   clk, rst                       - core clock, synchronous active-high reset
//   io_addr/io_rd/io_wr/io_wrdata  - CPU IO port (addr 0..7 = block bytes, STATUS_ADDR = status/control)
//   io_rddata                      - combinational read data for io_addr
//   in_valid/in_ready/in_data      - host block input (byte 0 = in_data[63:56])
//   out_valid/out_ready/out_data   - result output, same byte order
//   out_timeout                    - result was forced by the watchdog
//
// Optional feature: define TEA_MBOX_TIMEOUT_EN to build the PEND/BUSY watchdog that forces
// a pass-through result after TIMEOUT_CYCLES cycles. Without it out_timeout is tied 0.

module tea_io_mailbox #(
    parameter logic [4:0] STATUS_ADDR    = 5'h1F,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  io_addr,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [7:0]  io_wrdata,
    output logic [7:0]  io_rddata,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_in_buf;
    logic [63:0] r_res_buf;
    logic        r_out_valid;

    logic        w_byte_addr;
    logic        w_stat_addr;
    logic        w_done_wr;
    logic        w_accept;
    logic        w_expire;
    logic        w_tmo_fire;
    logic        w_in_flight;
    logic [7:0]  w_status;

    assign w_byte_addr = (io_addr[4:3] == 2'b00);
    assign w_stat_addr = (io_addr == STATUS_ADDR);
    assign w_done_wr   = io_wr && w_stat_addr && io_wrdata[0];
    assign w_in_flight = (r_state == PEND) || (r_state == BUSY);

`ifdef TEA_MBOX_TIMEOUT_EN
    localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYCLES - 1);

    logic [12:0] r_tmo_cnt;
    logic        r_out_timeout;

    assign w_expire    = w_in_flight && (r_tmo_cnt == TMO_LAST);
    assign out_timeout = r_out_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt     <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            // Counter restarts on the accept edge, i.e. on entry to PEND.
            if (w_accept) begin
                r_tmo_cnt     <= '0;
                r_out_timeout <= 1'b0;
            end else if (w_in_flight) begin
                r_tmo_cnt <= r_tmo_cnt + 13'd1;
            end
            if (w_tmo_fire) begin
                r_out_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_expire    = 1'b0;
    assign out_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_tmo_fire  = 1'b0;
        in_ready    = !rst && (r_state == IDLE);
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (w_expire) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = DONE;
                end else if (io_rd && w_byte_addr) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A firmware done write beats a watchdog expiry in the same cycle.
                if (w_done_wr) begin
                    w_state_nxt = DONE;
                end else if (w_expire) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: block capture, firmware result bytes, result valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_buf    <= '0;
            r_res_buf   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_buf  <= in_data;
                r_res_buf <= '0;
            end
            if ((r_state == BUSY) && io_wr && w_byte_addr && !w_tmo_fire) begin
                for (int i = 0; i < 8; i++) begin
                    if (io_addr[2:0] == i[2:0]) begin
                        r_res_buf[63-8*i -: 8] <= io_wrdata;
                    end
                end
            end
            // Watchdog completion returns the original block untouched.
            if (w_tmo_fire) begin
                r_res_buf <= r_in_buf;
            end
            if ((r_state != DONE) && (w_state_nxt == DONE)) begin
                r_out_valid <= 1'b1;
            end else if ((r_state == DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_res_buf;

    // Status: {4'b0, timeout, valid, busy, req_n}; req_n is low while the block awaits firmware.
    assign w_status = {4'b0000, out_timeout, r_out_valid, (r_state == BUSY), !w_in_flight};

    // Read data is purely address-decoded; io_rd only matters for the PEND->BUSY step.
    always_comb begin
        io_rddata = 8'h00;
        if (w_byte_addr) begin
            for (int i = 0; i < 8; i++) begin
                if (io_addr[2:0] == i[2:0]) begin
                    io_rddata = r_in_buf[63-8*i -: 8];
                end
            end
        end else if (w_stat_addr) begin
            io_rddata = w_status;
        end
    end

endmodule

// File: tb/tb_tea_io_mailbox.sv
module tb_tea_io_mailbox;

    localparam logic [4:0] STAT = 5'h1F;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  io_addr;
    logic        io_rd;
    logic        io_wr;
    logic [7:0]  io_wrdata;
    logic [7:0]  io_rddata;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_timeout;

    tea_io_mailbox #(
        .STATUS_ADDR    (STAT),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io_addr     (io_addr),
        .io_rd       (io_rd),
        .io_wr       (io_wr),
        .io_wrdata   (io_wrdata),
        .io_rddata   (io_rddata),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_timeout (out_timeout)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          sink_mode = 0;   // 0 random, 1 hold low, 2 hold high
    logic [63:0] exp_q[$];
    logic        exp_t_q[$];
    logic [63:0] mon_prev;
    bit          mon_have;
    logic [63:0] mon_e;
    logic        mon_et;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int i);
        return v[63-8*i -: 8];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [7:0] e, input string nm);
        io_addr = a;
        #1;
        chk(nm, 64'(io_rddata), 64'(e));
    endtask

    task automatic io_write(input logic [4:0] a, input logic [7:0] d);
        io_addr   = a;
        io_wrdata = d;
        io_wr     = 1'b1;
        cyc();
        io_wr = 1'b0;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!in_ready && w < 200) begin
            cyc();
            w++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
    endtask

    // One complete block: accept, firmware traffic, done (or reset abort).
    task automatic run_block(input logic [63:0] d, input bit directed, input bit abort);
        logic [63:0] res;
        logic [4:0]  a;
        logic [7:0]  v;
        int          n;
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        res = '0;
        rd_chk(STAT, 8'h00, "stat_pend");
        a = 5'($urandom_range(0, 7));
        rd_chk(a, byte_of(d, int'(a)), "inbuf_byte");
        if (directed) begin
            rd_chk(5'd0, 8'h12, "dir_byte0");
            rd_chk(5'd3, 8'h78, "dir_byte3");
            rd_chk(5'd7, 8'h44, "dir_byte7");
            rd_chk(5'h10, 8'h00, "dir_unmapped");
            io_write(5'd2, 8'h55);
            rd_chk(STAT, 8'h00, "pend_wr_ignored");
        end else begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                case ($urandom_range(0, 2))
                    0: io_write(5'($urandom_range(0, 7)), 8'($urandom));
                    1: io_write(STAT, 8'($urandom) | 8'h01);
                    default: begin
                        io_addr = 5'($urandom_range(8, 31));
                        io_rd   = 1'b1;
                        cyc();
                        io_rd = 1'b0;
                    end
                endcase
            end
            rd_chk(STAT, 8'h00, "stat_pend_hold");
        end
        io_addr = 5'($urandom_range(0, 7));
        io_rd   = 1'b1;
        cyc();
        io_rd = 1'b0;
        rd_chk(STAT, 8'h02, "stat_busy");
        if (directed) begin
            io_write(STAT, 8'h00);
            rd_chk(STAT, 8'h02, "stat_wr0_ignored");
            for (int i = 0; i < 8; i++) begin
                io_write(5'(i), 8'(8'hA0 + i));
                res[63-8*i -: 8] = 8'(8'hA0 + i);
            end
        end else begin
            n = $urandom_range(0, 9);
            repeat (n) begin
                a = 5'($urandom_range(0, 7));
                v = 8'($urandom);
                case ($urandom_range(0, 4))
                    0, 1: begin
                        io_write(a, v);
                        res[63-8*a -: 8] = v;
                    end
                    2: io_write(5'($urandom_range(8, 30)), v);
                    3: io_write(STAT, v & 8'hFE);
                    default: begin
                        io_addr   = a;
                        io_wrdata = v;
                        io_wr     = 1'b1;
                        io_rd     = 1'b1;
                        #1;
                        chk("rd_during_wr", 64'(io_rddata), 64'(byte_of(d, int'(a))));
                        cyc();
                        io_wr = 1'b0;
                        io_rd = 1'b0;
                        res[63-8*a -: 8] = v;
                    end
                endcase
            end
        end
        if (abort) begin
            rst = 1'b1;
            #1;
            chk("ready_in_rst", 64'(in_ready), 64'd0);
            cyc();
            rst = 1'b0;
            rd_chk(STAT, 8'h01, "stat_after_abort");
            repeat (3) begin
                cyc();
                chk("no_out_after_abort", 64'(out_valid), 64'd0);
            end
        end else begin
            exp_q.push_back(res);
            exp_t_q.push_back(1'b0);
            io_write(STAT, 8'($urandom) | 8'h01);
            rd_chk(STAT, 8'h05, "stat_done");
            chk("out_valid_done", 64'(out_valid), 64'd1);
            if (directed) chk("dir_out_data", out_data, 64'hA0A1A2A3_A4A5A6A7);
        end
    endtask

    // Host result sink
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            case (sink_mode)
                0: out_ready = 1'($urandom_range(0, 1));
                1: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        mon_have = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !out_valid) begin
                mon_have = 1'b0;
            end else begin
                if (mon_have) chk("out_hold", out_data, mon_prev);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_out: got %0h with no result expected", out_data);
                    end else begin
                        mon_e  = exp_q.pop_front();
                        mon_et = exp_t_q.pop_front();
                        chk("out_data", out_data, mon_e);
                        chk("out_timeout", 64'(out_timeout), 64'(mon_et));
                    end
                    mon_have = 1'b0;
                end else begin
                    mon_have = 1'b1;
                    mon_prev = out_data;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [63:0] d;
        rst       = 1'b1;
        io_addr   = '0;
        io_rd     = 1'b0;
        io_wr     = 1'b0;
        io_wrdata = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (10) cyc();
        chk("ready_during_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        cyc();
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        chk("out_valid_after_rst", 64'(out_valid), 64'd0);
        chk("out_timeout_after_rst", 64'(out_timeout), 64'd0);
        rd_chk(STAT, 8'h01, "stat_idle");

        // Directed block with a held-off host
        sink_mode = 1;
        run_block(64'h12345678_11223344, 1'b1, 1'b0);
        repeat (5) begin
            cyc();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_data", out_data, 64'hA0A1A2A3_A4A5A6A7);
        end
        sink_mode = 2;
        cyc();
        chk("idle_after_hs_valid", 64'(out_valid), 64'd0);
        chk("idle_after_hs_ready", 64'(in_ready), 64'd1);
        rd_chk(STAT, 8'h01, "stat_idle_again");
        sink_mode = 0;

        // Randomized blocks, one aborted by reset mid-BUSY
        for (int b = 0; b < 20; b++) begin
            run_block({$urandom, $urandom}, 1'b0, b == 7);
        end

`ifdef TEA_MBOX_TIMEOUT_EN
        sink_mode = 1;
        wait_ready();
        d = {$urandom, $urandom};
        exp_q.push_back(d);
        exp_t_q.push_back(1'b1);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            cyc();
            n++;
        end
        chk("tmo_latency", 64'(n), 64'd16);
        chk("tmo_flag", 64'(out_timeout), 64'd1);
        chk("tmo_data", out_data, d);
        rd_chk(STAT, 8'h0D, "stat_tmo");
`endif

        sink_mode = 2;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        repeat (2) cyc();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tea_io_mailbox.md
Name: tea_io_mailbox

Overview:
Synthesizable IO-bus responder that sits on the tea_cpu IO port (io_addr/io_rd/io_wr/io_rddata/io_wrdata) and is the peripheral end of the CPU's IO protocol. Host side accepts a 64-bit TEA block over a valid/ready handshake and presents it to firmware as eight byte registers plus a request/done status register. Firmware writes eight result bytes, then sets done. The block returns the 64-bit result to the host over a second valid/ready handshake.

Parameters:
STATUS_ADDR, 5'h1F, IO address of the status/control register
TIMEOUT_CYCLES, 4096, cycles allowed in PEND+BUSY before forced completion (only used with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
io_addr  input  5  CPU IO address
io_rd  input  1  CPU IO read strobe
io_wr  input  1  CPU IO write strobe
io_wrdata  input  8  CPU IO write data
io_rddata  output  8  CPU IO read data, combinational from io_addr
in_valid  input  1  host block valid
in_ready  output  1  block accepts host block
in_data  input  64  host block; byte 0 = in_data[63:56] ... byte 7 = in_data[7:0]
out_valid  output  1  result valid
out_ready  input  1  host accepts result
out_data  output  64  result, same byte order as in_data
out_timeout  output  1  result produced by timeout (tied 0 without the optional feature)

Behaviour:
- Single clock domain; all state updates on posedge clk. rst has priority over every other event.
- rst: state=IDLE; in_buf=0; res_buf=0; out_valid=0; out_timeout=0; timeout counter=0.
- in_ready is 0 while rst=1. Otherwise in_ready = (state==IDLE).
- States: IDLE, PEND, BUSY, DONE.
- IDLE:
  - in_valid&&in_ready: capture in_data into in_buf and clear res_buf to 0 in the same edge, then go to PEND.
- PEND:
  - Block is waiting for firmware.
  - io_rd with io_addr in 0..7: go to BUSY.
- BUSY:
  - io_wr with io_addr in 0..7: res_buf byte[io_addr] <= io_wrdata.
  - io_wr with io_addr==STATUS_ADDR and io_wrdata[0]=1: go to DONE.
  - io_wr to STATUS_ADDR with io_wrdata[0]=0: ignored.
- DONE:
  - out_valid=1; out_data=res_buf.
  - out_valid&&out_ready: go to IDLE and clear out_valid on the same edge.
  - in_ready stays 0 until the block is back in IDLE, so there is no same-cycle accept.
- io_wr to addresses 0..7 outside BUSY: ignored. io_wr to any address 8..30: ignored.
- io_rddata is combinational; io_rd is not required for the read value, only for the PEND->BUSY transition.
  - Addresses 0..7: in_buf byte.
  - STATUS_ADDR: {4'b0, out_timeout, out_valid, busy, req_n}, where:
    - req_n = 0 in PEND/BUSY, else 1
    - busy = (state==BUSY)
  - All other addresses: 8'h00.
- Simultaneous io_rd and io_wr in one cycle: read returns the pre-write value; the write takes effect at the edge.
- The status register reads 8'h01 in IDLE, 8'h00 in PEND, 8'h02 in BUSY, and 8'h05 in DONE.
- out_data holds res_buf stable while out_valid=1. Host changes to in_data are ignored outside the IDLE accept edge.
- Reset mid-operation (any state) returns to IDLE. A block in flight is discarded and no out_valid is produced.

Optional Feature:
TEA_MBOX_TIMEOUT_EN
- Defined:
  - A 13-bit counter clears on entry to PEND and increments each cycle in PEND or BUSY.
  - When the counter reaches TIMEOUT_CYCLES-1, the next edge goes to DONE with out_data=in_buf (pass-through) and out_timeout=1.
  - out_timeout is cleared on the IDLE accept edge.
  - A firmware done write in the same cycle as expiry wins: out_timeout stays 0 and res_buf is output.
- Undefined:
  - No counter logic is built.
  - out_timeout is constant 0, and status bit3 reads 0.

Test Plan:
- Reset 10 cycles, release. Status read -> 8'h01; in_ready=1 the cycle after release; out_valid=0.
- Accept in_data=64'h12345678_11223344. Status -> 8'h00; io_addr 0 -> 8'h12, addr 3 -> 8'h78, addr 7 -> 8'h44, addr 5'h10 -> 8'h00.
- io_rd addr 0, then status -> 8'h02. Write bytes 8'hA0..8'hA7 to addrs 0..7, then write 8'h01 to 5'h1F -> out_valid=1, out_data=64'hA0A1A2A3_A4A5A6A7, status 8'h05.
- Hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0. Assert out_ready -> IDLE next cycle, in_ready=1. A second block then runs correctly.
- Write 8'h55 to addr 2 in PEND, and write 8'h00 to 5'h1F in BUSY -> both ignored. Assert rst during BUSY -> status 8'h01, no out_valid.
- With TEA_MBOX_TIMEOUT_EN and TIMEOUT_CYCLES=16, accept a block and send no CPU traffic -> out_valid after 16 cycles, out_data=in_data, out_timeout=1, status 8'h0D.
